switch_btn_reader: RTL
======================

// Module: switch_btn_reader
// PURPOSE
// - Memory-mapped input peripheral read by the bus bridge. It is the read-side counterpart of the LED output register.
// - Synchronises and debounces board switches and push-buttons.
// - Records button press events in sticky, clear-on-read flags.
// - Returns the selected register to the bridge one cycle after a read strobe.
// PARAMETERS
// - SW_W      24     number of slide switches
// - BTN_W     5      number of push-buttons (BTN_W <= 16)
// - TICK_DIV  50000  clk cycles per debounce tick (1 ms at 50 MHz); >= 2
// - DEB_TICKS 16     consecutive ticks an input must differ from its stable value before it is accepted; >= 1
// PORTS
// - clk               in   1      system clock, all logic on rising edge
// - rst_n             in   1      asynchronous, active-low reset
// - re                in   1      read strobe from bridge, one-cycle pulse per access
// - addr_from_bridge  in   32     byte address; only [3:2] decoded, the bridge performs chip-select
// - sw_in             in   SW_W   raw switch levels, asynchronous to clk
// - btn_in            in   BTN_W  raw button levels, active-high, asynchronous to clk
// - rdata_to_bridge   out  32     read data, registered
// - rvalid            out  1      one-cycle pulse marking rdata_to_bridge valid
// BEHAVIOUR
// - Reset values:
//   - rdata_to_bridge = 0, rvalid = 0
//   - sync stages, stable values, event flags, tick counter and per-bit counters all = 0
// - Input path: every sw_in/btn_in bit passes through a 2-FF synchroniser; no logic between the two stages.
// - Tick prescaler:
//   - Counts 0..TICK_DIV-1 and wraps to 0.
//   - tick = 1 for exactly one cycle when count == TICK_DIV-1.
// - Debounce, per bit, independent:
//   - sync == stable: counter forced to 0 every cycle.
//   - sync != stable on a tick: counter + 1.
//   - When a tick arrives with counter == DEB_TICKS-1: stable <= sync and counter <= 0.
//   - A bounce (sync returns to stable) before acceptance clears the counter; no partial credit is kept.
//   - Counter width = $clog2(DEB_TICKS+1).
// - Press event: set evt[i] in the cycle stable_btn[i] goes 0->1. Release sets nothing.
// - Register map, selected by addr[3:2] at the cycle re is high:
//   - 0x0: {(32-SW_W)'0, stable_sw}
//   - 0x4: {(32-BTN_W)'0, stable_btn}
//   - 0x8: {(32-BTN_W)'0, evt}; clear-on-read
//   - 0xC: status {30'0, |stable_sw, |evt}
// - Read timing:
//   - re at cycle N -> rdata_to_bridge and rvalid=1 at cycle N+1.
//   - rdata_to_bridge holds its last value when re=0; rvalid=0 in every cycle without a read.
// - Back-to-back re every cycle is legal; each read is answered in order, one per cycle.
// - Event clear on a 0x8 read:
//   - evt is cleared in the same edge that captures its value into rdata.
//   - A press event arriving in that same cycle wins: that bit stays 1, and the returned data excludes it.
// - Reads of 0x0, 0x4 and 0xC have no side effects.
// - rst_n low mid-operation:
//   - All state returns to reset values immediately (asynchronous).
//   - Pending events are lost; no rvalid is produced for a read in flight.
//   - On release, stable = 0, so held-down switches/buttons are re-accepted after DEB_TICKS ticks.
//   - Held buttons then raise evt once.
// TESTING (sim params TICK_DIV=4, DEB_TICKS=3, SW_W=24, BTN_W=5)
// - Reset, then re with addr 0x0/0x4/0x8/0xC -> rvalid one cycle after each re, all data 0.
// - sw_in=24'hA5A5A5 held steady:
//   - reads 0 before the 3rd tick after sync;
//   - read 0x0 after acceptance -> 32'h00A5A5A5; read 0xC -> 32'h2.
// - btn_in[2] glitches high for 5 cycles (< 3 ticks) -> stable_btn and evt stay 0; read 0x8 -> 0.
// - btn_in[0] held high for 20 cycles:
//   - read 0x4 -> 32'h1; read 0x8 -> 32'h1; second read 0x8 -> 32'h0.
// - btn_in[1] is accepted exactly in the cycle re reads 0x8 while evt=0x1:
//   - returned data = 32'h1;
//   - next read 0x8 -> 32'h2.
// - Assert rst_n=0 while sw_in=24'hFFFFFF is stable and re is pending -> no rvalid, all outputs 0.
//   - After release, 0x0 reads 0 until 3 ticks pass, then 32'h00FFFFFF.

Source files
------------

// File: rtl/switch_btn_reader.sv
// Memory-mapped switch / push-button reader: 2-FF synchronisers, tick-based
// debounce, sticky clear-on-read press events, registered single-cycle reads.
module switch_btn_reader #(
  parameter int SW_W      = 24,
  parameter int BTN_W     = 5,
  parameter int TICK_DIV  = 50000,
  parameter int DEB_TICKS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             re,
  input  logic [31:0]      addr_from_bridge,
  input  logic [SW_W-1:0]  sw_in,
  input  logic [BTN_W-1:0] btn_in,
  output logic [31:0]      rdata_to_bridge,
  output logic             rvalid
);

  localparam int N  = SW_W + BTN_W;
  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = $clog2(DEB_TICKS + 1);

  typedef enum logic [1:0] {
    REG_SW     = 2'd0,
    REG_BTN    = 2'd1,
    REG_EVT    = 2'd2,
    REG_STATUS = 2'd3
  } reg_sel_e;

  // Switches occupy [SW_W-1:0], buttons [N-1:SW_W] of every per-input vector.
  logic [N-1:0]     r_meta;
  logic [N-1:0]     r_sync;
  logic [N-1:0]     r_stable;
  logic [CW-1:0]    r_deb_cnt [N];
  logic [TW-1:0]    r_tick_cnt;
  logic [BTN_W-1:0] r_evt;

  logic             w_tick;
  logic [N-1:0]     w_accept;
  logic [BTN_W-1:0] w_press;
  logic             w_evt_rd;
  logic [31:0]      w_rdata;
  reg_sel_e         w_sel;
  logic             w_unused_addr;

  assign w_sel         = reg_sel_e'(addr_from_bridge[3:2]);
  assign w_unused_addr = ^{addr_from_bridge[31:4], addr_from_bridge[1:0]};
  assign w_tick        = (r_tick_cnt == TW'(TICK_DIV - 1));
  assign w_evt_rd      = re && (w_sel == REG_EVT);

  // A bit is accepted on the tick that completes its DEB_TICKS-th differing tick.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_accept[i] = w_tick && (r_sync[i] != r_stable[i]) &&
                    (r_deb_cnt[i] == CW'(DEB_TICKS - 1));
    end
  end

  assign w_press = w_accept[N-1:SW_W] & r_sync[N-1:SW_W];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta     <= '0;
      r_sync     <= '0;
      r_tick_cnt <= '0;
    end else begin
      r_meta     <= {btn_in, sw_in};
      r_sync     <= r_meta;
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
    end
  end

  // NOTE: the counter array is reset element by element; it is a bank of flops,
  // not RAM, and a stale count after reset would shorten the first debounce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= '0;
      for (int i = 0; i < N; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_stable <= r_stable ^ w_accept;
      for (int i = 0; i < N; i++) begin
        if (r_sync[i] == r_stable[i] || w_accept[i]) r_deb_cnt[i] <= '0;
        else if (w_tick)                             r_deb_cnt[i] <= r_deb_cnt[i] + CW'(1);
      end
    end
  end

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    w_rdata = '0;
    unique case (w_sel)
      REG_SW:     w_rdata = 32'(r_stable[SW_W-1:0]);
      REG_BTN:    w_rdata = 32'(r_stable[N-1:SW_W]);
      REG_EVT:    w_rdata = 32'(r_evt);
      REG_STATUS: w_rdata = {30'd0, |r_stable[SW_W-1:0], |r_evt};
      default:    w_rdata = '0;
    endcase
  end

  // A press landing on the clearing edge survives; the returned data predates it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt           <= '0;
      rdata_to_bridge <= '0;
      rvalid          <= 1'b0;
    end else begin
      r_evt  <= w_evt_rd ? w_press : (r_evt | w_press);
      rvalid <= re;
      if (re) rdata_to_bridge <= w_rdata;
    end
  end

endmodule
